data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_DEPTH_LOG2, default 10, gives log2 of the doubleword count (1024 x 64 b = 8 KiB).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 req_valid  input  1  MEM-stage access request.
REQ-005 mem_write  input  1  1 = store, 0 = load.
REQ-006 mem_type  input  MemTypeBusBits (3)  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
REQ-007 addr  input  DataBusBits (64)  byte address (EX ALU result).
REQ-008 wdata  input  64  store data, least-significant-aligned.
REQ-009 req_ready  output  1  request accepted this cycle; low stalls upstream.
REQ-010 rdata_valid  output  1  one-cycle load-response pulse.
REQ-011 rdata  output  64  extended load data.
REQ-012 misalign  output  1  one-cycle fault pulse.

Function
REQ-013 FSM states SHALL be IDLE, LOAD_WAIT and LOAD_RESP.
REQ-014 Acceptance SHALL be req_valid && req_ready; req_ready = 1 in IDLE and LOAD_RESP, 0 in LOAD_WAIT.
REQ-015 Alignment rules SHALL be: H/HU need addr[0]=0, W/WU need addr[1:0]=0, D needs addr[2:0]=0; B/BU are always aligned.
REQ-016 A misaligned access or mem_type 111 SHALL perform no RAM access, pulse misalign in the following cycle, and move to IDLE.
REQ-017 The RAM index SHALL be addr[MEM_DEPTH_LOG2+2:3]; higher address bits SHALL be ignored (wrap-around aliasing).
REQ-018 A store SHALL write the RAM at the acceptance edge with byte enables from size and addr[2:0], and wdata shifted by addr[2:0]*8; BU/HU/WU SHALL store as B/H/W.
REQ-019 A store SHALL leave or return the FSM to IDLE; one store per cycle is allowed.
REQ-020 A load SHALL issue the RAM read at acceptance, latch addr[2:0] and mem_type, and go to LOAD_WAIT.
REQ-021 From LOAD_WAIT the FSM SHALL go to LOAD_RESP, registering the extracted and extended lane into rdata with rdata_valid = 1 for that cycle.
REQ-022 Load latency SHALL be 2 cycles from the acceptance edge to rdata_valid high; back-to-back loads yield one response every 2 cycles.
REQ-023 In LOAD_RESP, a new load SHALL be accepted and go to LOAD_WAIT; a store or no request SHALL go to IDLE.
REQ-024 Extension SHALL be: B/H/W sign-extend to 64; BU/HU/WU zero-extend; D passes through.
REQ-025 rdata SHALL hold its last value while rdata_valid = 0.
REQ-026 A load accepted the cycle after a store to the same doubleword SHALL return the stored bytes.
REQ-027 A store and a load response in the same cycle (store accepted in LOAD_RESP) SHALL not corrupt the response.
REQ-028 Requests while req_ready = 0 SHALL be ignored; upstream holds them.

Reset
REQ-029 On reset = 0: state = IDLE, req_ready = 0 during reset, rdata_valid = 0, misalign = 0, rdata = DataZero.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 Reset during LOAD_WAIT/LOAD_RESP SHALL discard the load with no rdata_valid pulse after release.
REQ-032 req_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 diagv2_const SHALL hold DataBusBits, MemTypeBusBits, the mem_type encodings, DataZero and the FSM state encodings.
REQ-034 Storage SHALL be a sub-module dmem_ram_64: single-port synchronous read, byte-enabled write, depth parameter.
REQ-035 Lane extraction, extension and byte-enable generation SHALL be combinational logic inside data_mem_responder.

Verification
REQ-036 SD 0x1122334455667788 @0x100, then LD @0x100 -> rdata_valid 2 cycles after load acceptance, rdata = 0x1122334455667788.
REQ-037 LB @0x107 -> 0x0000000000000011; SB 0x80 @0x101 then LB @0x101 -> 0xFFFFFFFFFFFFFF80, LBU @0x101 -> 0x80.
REQ-038 LW @0x102 -> misalign pulse next cycle, no rdata_valid, RAM unchanged; mem_type 111 -> same result.
REQ-039 Back-to-back LD @0x0, LD @0x8 with req_valid held -> req_ready pattern 1,0,1,0; two rdata_valid pulses, each with correct data.
REQ-040 Assert reset while in LOAD_WAIT -> no rdata_valid after release; req_ready = 1 first cycle after release; SD @(0x100 + 8*1024) aliases index 32.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared constants, encodings and access-rule helpers for the data-memory responder.
package diagv2_const;

  localparam int DataBusBits    = 64;
  localparam int MemTypeBusBits = 3;

  localparam logic [MemTypeBusBits-1:0] MT_B   = 3'b000;
  localparam logic [MemTypeBusBits-1:0] MT_H   = 3'b001;
  localparam logic [MemTypeBusBits-1:0] MT_W   = 3'b010;
  localparam logic [MemTypeBusBits-1:0] MT_D   = 3'b011;
  localparam logic [MemTypeBusBits-1:0] MT_BU  = 3'b100;
  localparam logic [MemTypeBusBits-1:0] MT_HU  = 3'b101;
  localparam logic [MemTypeBusBits-1:0] MT_WU  = 3'b110;
  localparam logic [MemTypeBusBits-1:0] MT_ILL = 3'b111;

  localparam logic [DataBusBits-1:0] DataZero = 64'h0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_RESP = 2'd2
  } state_t;

  // Illegal encodings and accesses not aligned to their natural size fault.
  function automatic logic is_fault(input logic [MemTypeBusBits-1:0] mt, input logic [2:0] off);
    logic f;
    case (mt)
      MT_B, MT_BU: f = 1'b0;
      MT_H, MT_HU: f = off[0];
      MT_W, MT_WU: f = |off[1:0];
      MT_D:        f = |off;
      default:     f = 1'b1;
    endcase
    return f;
  endfunction

  // Unshifted byte-enable pattern for an access of the given size.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [DataBusBits-1:0] extend_lane(input logic [MemTypeBusBits-1:0] mt,
                                                         input logic [DataBusBits-1:0] lane);
    logic [DataBusBits-1:0] v;
    case (mt)
      MT_B:    v = {{56{lane[7]}}, lane[7:0]};
      MT_H:    v = {{48{lane[15]}}, lane[15:0]};
      MT_W:    v = {{32{lane[31]}}, lane[31:0]};
      MT_BU:   v = {56'h0, lane[7:0]};
      MT_HU:   v = {48'h0, lane[15:0]};
      MT_WU:   v = {32'h0, lane[31:0]};
      default: v = lane;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dmem_ram_64.sv
// Single-port 64-bit RAM: synchronous read, byte-enabled write, contents never reset.
module dmem_ram_64 #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [7:0]            be,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem_r [0:(1<<DEPTH_LOG2)-1];
  logic [63:0] rdata_r;

  // Byte-masked write or registered read; the read register holds across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) begin
            mem_r[index][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end else begin
        rdata_r <= mem_r[index];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: stores in one cycle, loads answer two cycles after acceptance.
module data_mem_responder
  import diagv2_const::*;
#(
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      mem_write,
  input  logic [MemTypeBusBits-1:0] mem_type,
  input  logic [DataBusBits-1:0]    addr,
  input  logic [DataBusBits-1:0]    wdata,
  output logic                      req_ready,
  output logic                      rdata_valid,
  output logic [DataBusBits-1:0]    rdata,
  output logic                      misalign
);

  state_t                    state_r;
  logic [2:0]                off_r;
  logic [MemTypeBusBits-1:0] type_r;
  logic [DataBusBits-1:0]    rdata_r;
  logic                      rdata_valid_r;
  logic                      misalign_r;

  logic                      ready_s;
  logic                      accept_s;
  logic                      fault_s;
  logic                      ram_en_s;
  logic [7:0]                be_s;
  logic [DataBusBits-1:0]    wdata_sh_s;
  logic [DataBusBits-1:0]    ram_q_s;
  logic [DataBusBits-1:0]    ext_s;
  logic [MEM_DEPTH_LOG2-1:0] index_s;
  logic                      unused_addr_s;

  // Request decode, store lane placement and load lane extraction.
  always_comb begin
    ready_s    = reset && (state_r != LOAD_WAIT);
    accept_s   = req_valid && ready_s;
    fault_s    = is_fault(mem_type, addr[2:0]);
    ram_en_s   = accept_s && !fault_s;
    index_s    = addr[MEM_DEPTH_LOG2+2:3];
    be_s       = size_mask(mem_type[1:0]) << addr[2:0];
    wdata_sh_s = wdata << {addr[2:0], 3'b000};
    ext_s      = extend_lane(type_r, ram_q_s >> {off_r, 3'b000});
  end

  // Upper address bits alias onto the RAM and are intentionally dropped.
  assign unused_addr_s = ^addr[DataBusBits-1:MEM_DEPTH_LOG2+3];

  dmem_ram_64 #(.DEPTH_LOG2(MEM_DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (mem_write),
    .be    (be_s),
    .index (index_s),
    .wdata (wdata_sh_s),
    .rdata (ram_q_s)
  );

  // Control FSM with registered response and fault pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      off_r         <= 3'b000;
      type_r        <= MT_B;
      rdata_r       <= DataZero;
      rdata_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      rdata_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
      case (state_r)
        IDLE, LOAD_RESP: begin
          if (accept_s && fault_s) begin
            misalign_r <= 1'b1;
            state_r    <= IDLE;
          end else if (accept_s && !mem_write) begin
            off_r   <= addr[2:0];
            type_r  <= mem_type;
            state_r <= LOAD_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_WAIT: begin
          rdata_r       <= ext_s;
          rdata_valid_r <= 1'b1;
          state_r       <= LOAD_RESP;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_s;
  assign rdata_valid = rdata_valid_r;
  assign rdata       = rdata_r;
  assign misalign    = misalign_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with a byte-array reference model and directed literal checks.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n_tb;
  logic        req_valid;
  logic        mem_write;
  logic [2:0]  mem_type;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        req_ready;
  logic        rdata_valid;
  logic [63:0] rdata;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  mdl [0:8191];
  bit          busy  [int];
  bit          exp_v [int];
  logic [63:0] exp_d [int];
  bit          exp_m [int];
  logic [63:0] last_rd = 64'h0;

  data_mem_responder #(.MEM_DEPTH_LOG2(10)) dut (
    .clk         (clk),
    .reset       (rst_n_tb),
    .req_valid   (req_valid),
    .mem_write   (mem_write),
    .mem_type    (mem_type),
    .addr        (addr),
    .wdata       (wdata),
    .req_ready   (req_ready),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] mt);
    return 1 << mt[1:0];
  endfunction

  // Value a load of this type must return, from the byte-level memory image.
  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] mt);
    int sz;
    int base;
    logic [63:0] v;
    sz = size_of(mt);
    base = int'(a[12:3]) * 8 + int'(a[2:0]);
    v = 64'h0;
    for (int i = 0; i < sz; i++) v = v | ({56'h0, mdl[base + i]} << (8 * i));
    if (mt[2] == 1'b0 && sz < 8 && v[8*sz-1]) v = v | ~((64'h1 << (8 * sz)) - 64'h1);
    return v;
  endfunction

  task automatic flush_model();
    busy.delete();
    exp_v.delete();
    exp_d.delete();
    exp_m.delete();
    last_rd = 64'h0;
  endtask

  // Reference model: a load occupies the following cycle and answers in the one after.
  always @(posedge clk) begin
    int sz;
    int base;
    if (rst_n_tb && req_valid && !busy.exists(cyc)) begin
      sz = size_of(mem_type);
      if (mem_type == 3'b111 || (int'(addr[2:0]) % sz) != 0) begin
        exp_m[cyc+1] = 1'b1;
      end else if (mem_write) begin
        base = int'(addr[12:3]) * 8 + int'(addr[2:0]);
        for (int i = 0; i < sz; i++) mdl[base + i] = wdata[8*i +: 8];
      end else begin
        busy[cyc+1]  = 1'b1;
        exp_d[cyc+2] = model_load(addr, mem_type);
        exp_v[cyc+2] = 1'b1;
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = rst_n_tb && !busy.exists(cyc);
    if (exp_v.exists(cyc)) last_rd = exp_d[cyc];
    chk("req_ready", {63'h0, req_ready}, {63'h0, exp_rdy});
    chk("rdata_valid", {63'h0, rdata_valid}, {63'h0, exp_v.exists(cyc)});
    chk("rdata", rdata, last_rd);
    chk("misalign", {63'h0, misalign}, {63'h0, exp_m.exists(cyc)});
  end

  // One request cycle; returns outputs sampled mid-cycle.
  task automatic drive(input bit v, input bit w, input logic [2:0] mt, input logic [63:0] a,
                       input logic [63:0] d, output bit rdy, output bit rv, output logic [63:0] rd,
                       output bit mis);
    @(negedge clk);
    req_valid = v; mem_write = w; mem_type = mt; addr = a; wdata = d;
    #1;
    rdy = req_ready; rv = rdata_valid; rd = rdata; mis = misalign;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input logic [63:0] exp, input int exp_lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 6 && !got) begin
      @(negedge clk);
      #1;
      n++;
      if (rdata_valid) got = 1'b1;
    end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    chk(nm, rdata, exp);
  endtask

  initial begin
    bit rdy, rv, mis;
    logic [63:0] rd;
    int nv;
    logic [2:0] mt;
    logic [63:0] a;

    rst_n_tb = 1'b0; req_valid = 1'b0; mem_write = 1'b0; mem_type = 3'b000;
    addr = 64'h0; wdata = 64'h0;
    for (int i = 0; i < 8192; i++) mdl[i] = 8'h00;

    repeat (3) @(posedge clk);
    #3;
    chk("ready_in_reset", {63'h0, req_ready}, 64'h0);
    chk("rdata_in_reset", rdata, 64'h0);
    rst_n_tb = 1'b1;
    #1;
    chk("ready_after_release", {63'h0, req_ready}, 64'h1);

    // Doubleword store then load.
    drive(1, 1, 3'b011, 64'h100, 64'h1122334455667788, rdy, rv, rd, mis);
    drive(1, 0, 3'b011, 64'h100, 64'h0, rdy, rv, rd, mis);
    wait_valid("ld_100", 64'h1122334455667788, 2);
    drive(1, 0, 3'b000, 64'h107, 64'h0, rdy, rv, rd, mis);
    wait_valid("lb_107", 64'h0000000000000011, 2);
    drive(1, 1, 3'b000, 64'h101, 64'h80, rdy, rv, rd, mis);
    drive(1, 0, 3'b000, 64'h101, 64'h0, rdy, rv, rd, mis);
    wait_valid("lb_101", 64'hFFFFFFFFFFFFFF80, 2);
    drive(1, 0, 3'b100, 64'h101, 64'h0, rdy, rv, rd, mis);
    wait_valid("lbu_101", 64'h0000000000000080, 2);
    drive(1, 0, 3'b001, 64'h106, 64'h0, rdy, rv, rd, mis);
    wait_valid("lh_106", 64'h0000000000001122, 2);

    // Faulting accesses leave memory alone.
    drive(1, 0, 3'b010, 64'h102, 64'h0, rdy, rv, rd, mis);
    drive(0, 0, 3'b000, 64'h0, 64'h0, rdy, rv, rd, mis);
    chk("lw_102_misalign", {63'h0, mis}, 64'h1);
    chk("lw_102_no_valid", {63'h0, rv}, 64'h0);
    drive(1, 1, 3'b111, 64'h100, 64'hFFFFFFFFFFFFFFFF, rdy, rv, rd, mis);
    drive(0, 0, 3'b000, 64'h0, 64'h0, rdy, rv, rd, mis);
    chk("type7_misalign", {63'h0, mis}, 64'h1);
    drive(1, 0, 3'b011, 64'h100, 64'h0, rdy, rv, rd, mis);
    wait_valid("ld_100_unchanged", 64'h1122334455668088, 2);

    // Back-to-back loads with the request held.
    drive(1, 1, 3'b011, 64'h0, 64'hDEADBEEF01234567, rdy, rv, rd, mis);
    drive(1, 1, 3'b011, 64'h8, 64'h0F1E2D3C4B5A6978, rdy, rv, rd, mis);
    drive(1, 0, 3'b011, 64'h0, 64'h0, rdy, rv, rd, mis);
    chk("b2b_ready0", {63'h0, rdy}, 64'h1);
    drive(1, 0, 3'b011, 64'h8, 64'h0, rdy, rv, rd, mis);
    chk("b2b_ready1", {63'h0, rdy}, 64'h0);
    drive(1, 0, 3'b011, 64'h8, 64'h0, rdy, rv, rd, mis);
    chk("b2b_ready2", {63'h0, rdy}, 64'h1);
    chk("b2b_first_valid", {63'h0, rv}, 64'h1);
    chk("b2b_first_data", rd, 64'hDEADBEEF01234567);
    drive(0, 0, 3'b000, 64'h0, 64'h0, rdy, rv, rd, mis);
    chk("b2b_ready3", {63'h0, rdy}, 64'h0);
    wait_valid("b2b_second", 64'h0F1E2D3C4B5A6978, 1);

    // Reset while a load is in flight.
    drive(1, 0, 3'b011, 64'h100, 64'h0, rdy, rv, rd, mis);
    #2;
    rst_n_tb = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #3;
    chk("ready_in_reset2", {63'h0, req_ready}, 64'h0);
    rst_n_tb = 1'b1;
    #1;
    chk("ready_after_release2", {63'h0, req_ready}, 64'h1);
    nv = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (rdata_valid) nv++;
    end
    chk("no_valid_after_reset", 64'(nv), 64'h0);
    drive(1, 1, 3'b011, 64'h100 + 64'd8192, 64'hCAFEF00D5566AA99, rdy, rv, rd, mis);
    drive(1, 0, 3'b011, 64'h100, 64'h0, rdy, rv, rd, mis);
    wait_valid("alias_index32", 64'hCAFEF00D5566AA99, 2);

    // Fill the whole memory so random loads have known contents.
    for (int i = 0; i < 1024; i++)
      drive(1, 1, 3'b011, 64'(i) * 64'd8, {$urandom, $urandom}, rdy, rv, rd, mis);

    for (int k = 0; k < 3000; k++) begin
      mt = ($urandom_range(0, 15) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(size_of(mt)) - 64'h1);
      drive(($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)), mt, a,
            {$urandom, $urandom}, rdy, rv, rd, mis);
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
